machine_timer: RTL

//  RISC-V machine timer/software-interrupt unit (CLINT-style) on the data bus.
//  - Holds 64-bit mtime, mtimecmp and msip.
//  - Drives irq_timer_o and irq_software_o into the exception unit's irq_timer_i and irq_software_i.
//  - The exception unit does the mie masking, so this block only generates the raw pending levels.

---
 rtl/machine_timer_if.sv | 37 +++
 rtl/machine_timer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/machine_timer_if.sv
`default_nettype none
// ============================================================================
// Module      : machine_timer_if
// Description : Data-bus interface of the machine timer. The bus master
//               drives the request side; the timer returns the grant and a
//               one-cycle-delayed response.
//   req_i    : bus request
//   we_i     : 1 = write, 0 = read
//   be_i     : byte enables (writes only)
//   addr_i   : byte address
//   data_i   : write data
//   gnt_o    : grant
//   rvalid_o : response valid
//   data_o   : read data
// Revision    : 1.0 - initial release
// ============================================================================
interface machine_timer_if;
    logic        req_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic        gnt_o;
    logic        rvalid_o;
    logic [31:0] data_o;

    modport master (
        output req_i, we_i, be_i, addr_i, data_i,
        input  gnt_o, rvalid_o, data_o
    );

    modport slave (
        input  req_i, we_i, be_i, addr_i, data_i,
        output gnt_o, rvalid_o, data_o
    );
endinterface
`default_nettype wire

// File: rtl/machine_timer.sv
`default_nettype none
// ============================================================================
// Module      : machine_timer
// Description : CLINT-style machine timer / software interrupt unit.
//               Holds 64-bit mtime and mtimecmp plus msip, and produces the
//               raw timer and software interrupt pending levels.
//   clk            : core clock
//   rst_n          : asynchronous active-low reset
//   bus            : data-bus slave port (machine_timer_if.slave)
//   irq_timer_o    : timer interrupt pending, registered (mtime >= mtimecmp)
//   irq_software_o : software interrupt pending (MSIP bit 0)
// Register map (addr_i[4:2]):
//   0 MTIME_LO, 1 MTIME_HI, 2 MTIMECMP_LO, 3 MTIMECMP_HI,
//   4 MSIP (bit0), 5 CTRL (bit0 EN, DIV at bit 8 up), 6/7 reserved
// Configuration macro : MTIME_SNAPSHOT_EN
//   When defined, a MTIME_LO read latches mtime[63:32] into a shadow that a
//   following MTIME_HI read returns, giving a tear-free LO-then-HI read.
// Revision    : 1.0 - initial release
// ============================================================================
module machine_timer #(
    parameter int DIV_WIDTH = 8
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    machine_timer_if.slave    bus,
    output logic              irq_timer_o,
    output logic              irq_software_o
);

    localparam logic [2:0] c_SEL_MTIME_LO    = 3'd0;
    localparam logic [2:0] c_SEL_MTIME_HI    = 3'd1;
    localparam logic [2:0] c_SEL_MTIMECMP_LO = 3'd2;
    localparam logic [2:0] c_SEL_MTIMECMP_HI = 3'd3;
    localparam logic [2:0] c_SEL_MSIP        = 3'd4;
    localparam logic [2:0] c_SEL_CTRL        = 3'd5;

    // Byte lanes of CTRL that carry the DIV field
    localparam logic [3:0] c_DIV_BE = (DIV_WIDTH > 8) ? 4'b0110 : 4'b0010;

    logic [63:0]          r_mtime;
    logic [63:0]          r_mtimecmp;
    logic                 r_msip;
    logic                 r_en;
    logic [DIV_WIDTH-1:0] r_div;
    logic [DIV_WIDTH-1:0] r_presc;
    logic                 r_rvalid;
    logic [31:0]          r_rdata;
    logic                 r_irq_timer;
`ifdef MTIME_SNAPSHOT_EN
    logic [31:0]          r_shadow;
`endif

    logic [2:0]  w_sel;
    logic        w_wr;
    logic        w_rd;
    logic        w_any_be;
    logic        w_tick;
    logic        w_div_wr;
    logic [31:0] w_ctrl;
    logic [31:0] w_ctrl_new;
    logic [31:0] w_rdata;
    logic        w_unused;

    function automatic logic [31:0] f_merge(
        input logic [31:0] old_v,
        input logic [31:0] new_v,
        input logic [3:0]  be
    );
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) res[8*b +: 8] = new_v[8*b +: 8];
        end
        return res;
    endfunction

    assign w_sel    = bus.addr_i[4:2];
    assign w_wr     = bus.req_i & bus.we_i;
    assign w_rd     = bus.req_i & ~bus.we_i;
    assign w_any_be = |bus.be_i;
    assign w_tick   = r_en && (r_presc == r_div);
    assign w_div_wr = w_wr && (w_sel == c_SEL_CTRL) && |(bus.be_i & c_DIV_BE);

    always_comb begin
        w_ctrl                   = '0;
        w_ctrl[0]                = r_en;
        w_ctrl[8 +: DIV_WIDTH]   = r_div;
    end

    assign w_ctrl_new = f_merge(w_ctrl, bus.data_i, bus.be_i);

    always_comb begin
        w_rdata = '0;
        case (w_sel)
            c_SEL_MTIME_LO:    w_rdata = r_mtime[31:0];
`ifdef MTIME_SNAPSHOT_EN
            c_SEL_MTIME_HI:    w_rdata = r_shadow;
`else
            c_SEL_MTIME_HI:    w_rdata = r_mtime[63:32];
`endif
            c_SEL_MTIMECMP_LO: w_rdata = r_mtimecmp[31:0];
            c_SEL_MTIMECMP_HI: w_rdata = r_mtimecmp[63:32];
            c_SEL_MSIP:        w_rdata = {31'd0, r_msip};
            c_SEL_CTRL:        w_rdata = w_ctrl;
            default:           w_rdata = '0;
        endcase
    end

    // Counter state. A bus write to either mtime half suppresses the
    // increment for that cycle; the written half takes the merged bytes and
    // the other half is left untouched (no carry across).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mtime    <= '0;
            r_mtimecmp <= '1;
            r_msip     <= 1'b0;
            r_en       <= 1'b0;
            r_div      <= '0;
            r_presc    <= '0;
        end else begin
            if (w_wr && w_any_be && (w_sel == c_SEL_MTIME_LO)) begin
                r_mtime[31:0]  <= f_merge(r_mtime[31:0], bus.data_i, bus.be_i);
            end else if (w_wr && w_any_be && (w_sel == c_SEL_MTIME_HI)) begin
                r_mtime[63:32] <= f_merge(r_mtime[63:32], bus.data_i, bus.be_i);
            end else if (w_tick) begin
                r_mtime <= r_mtime + 64'd1;
            end

            if (!r_en || w_div_wr || w_tick) begin
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + DIV_WIDTH'(1);
            end

            if (w_wr && (w_sel == c_SEL_MTIMECMP_LO)) begin
                r_mtimecmp[31:0]  <= f_merge(r_mtimecmp[31:0], bus.data_i, bus.be_i);
            end
            if (w_wr && (w_sel == c_SEL_MTIMECMP_HI)) begin
                r_mtimecmp[63:32] <= f_merge(r_mtimecmp[63:32], bus.data_i, bus.be_i);
            end
            if (w_wr && (w_sel == c_SEL_MSIP) && bus.be_i[0]) begin
                r_msip <= bus.data_i[0];
            end
            if (w_wr && (w_sel == c_SEL_CTRL)) begin
                r_en  <= w_ctrl_new[0];
                r_div <= w_ctrl_new[8 +: DIV_WIDTH];
            end
        end
    end

    // Bus response and registered interrupt compare
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rvalid    <= 1'b0;
            r_rdata     <= '0;
            r_irq_timer <= 1'b0;
        end else begin
            r_rvalid    <= bus.req_i;
            r_rdata     <= w_rd ? w_rdata : 32'd0;
            r_irq_timer <= (r_mtime >= r_mtimecmp);
        end
    end

`ifdef MTIME_SNAPSHOT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow <= '0;
        end else if (w_rd && (w_sel == c_SEL_MTIME_LO)) begin
            r_shadow <= r_mtime[63:32];
        end
    end
`endif

    assign bus.gnt_o      = bus.req_i;
    assign bus.rvalid_o   = r_rvalid;
    assign bus.data_o     = r_rdata;
    assign irq_timer_o    = r_irq_timer;
    assign irq_software_o = r_msip;

    assign w_unused = ^{w_ctrl_new[31:8+DIV_WIDTH], w_ctrl_new[7:1],
                        bus.addr_i[31:5], bus.addr_i[1:0]};

endmodule
`default_nettype wire
